arpeggio_sequencer: RTL and testbench

//  Parametrised arpeggiator core. Produces a sine-table read address stepped at a note-dependent rate.

---
 rtl/arpeggio_sequencer.sv | 152 +++++++++++++++
 tb/tb_arpeggio_sequencer.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/arpeggio_sequencer.sv
// Arpeggiator core: steps a sine-table read address at a rate set by the base pitch
// and the current note of an up/down/up-down/hold pattern.
module arpeggio_sequencer #(
   parameter int NOTES       = 4,
   parameter int NOTE_TICKS  = 50_000_000,
   parameter int SW_BITS     = 8,
   parameter int BASE_OFFSET = 746,
   parameter int DIV_BITS    = 12,
   parameter int ADDR_BITS   = 8
) (
   input  logic                 CLK100MHZ,
   input  logic                 CPU_RESETN,
   input  logic [SW_BITS-1:0]   base_sel,
   input  logic [1:0]           mode,
   input  logic                 toggle,
   output logic [ADDR_BITS-1:0] addra,
   output logic                 addr_step,
   output logic [2:0]           note_idx,
   output logic                 note_strobe,
   output logic                 arp_active
);

   localparam int TW = (NOTE_TICKS > 1) ? $clog2(NOTE_TICKS) : 1;
   localparam int PW = DIV_BITS + 3;
   localparam logic [2:0]          LAST_NOTE = 3'(NOTES - 1);
   localparam logic [TW-1:0]       TMR_LAST  = TW'(NOTE_TICKS - 1);
   localparam logic [DIV_BITS-1:0] BASE_DIV  = DIV_BITS'(BASE_OFFSET);

   localparam logic [1:0] MODE_HOLD   = 2'b00;
   localparam logic [1:0] MODE_UP     = 2'b01;
   localparam logic [1:0] MODE_DOWN   = 2'b10;
   localparam logic [1:0] MODE_BOUNCE = 2'b11;

   typedef enum logic {DIR_UP, DIR_DOWN} dir_t;

   function automatic logic [2:0] ratio_num(input logic [2:0] i);
      case (i)
         3'd1:       ratio_num = 3'd4;
         3'd2, 3'd4: ratio_num = 3'd2;
         default:    ratio_num = 3'd1;
      endcase
   endfunction

   function automatic logic [2:0] ratio_den(input logic [2:0] i);
      case (i)
         3'd0:             ratio_den = 3'd1;
         3'd2, 3'd5:       ratio_den = 3'd3;
         3'd3:             ratio_den = 3'd2;
         3'd6:             ratio_den = 3'd4;
         default:          ratio_den = 3'd5;
      endcase
   endfunction

   // A zero divider would stall the step counter, so the floor is one cycle.
   function automatic logic [DIV_BITS-1:0] sat_div(input logic [PW-1:0] q);
      sat_div = (q == '0) ? DIV_BITS'(1) : DIV_BITS'(q);
   endfunction

   logic [DIV_BITS-1:0] fb_p1;
   logic [2:0]          idx_p1;
   logic [DIV_BITS-1:0] div_p2;
   logic [PW-1:0]       prod;
   logic [PW-1:0]       quot;
   logic [DIV_BITS-1:0] cnt;
   logic [TW-1:0]       tmr;
   dir_t                dir;

   always_comb begin
      prod = PW'(fb_p1) * PW'(ratio_num(idx_p1));
      quot = prod / PW'(ratio_den(idx_p1));
   end

   // Stage 1: base divider and note index; stage 2: scaled, clamped divider
   always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
         fb_p1  <= BASE_DIV;
         idx_p1 <= '0;
         div_p2 <= BASE_DIV;
      end else begin
         fb_p1  <= BASE_DIV + DIV_BITS'(base_sel);
         idx_p1 <= note_idx;
         div_p2 <= sat_div(quot);
      end
   end

   // >= rather than == so a shrinking divider fires on the next cycle
   always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
         cnt       <= '0;
         addra     <= '0;
         addr_step <= 1'b0;
      end else if (cnt >= div_p2 - DIV_BITS'(1)) begin
         cnt       <= '0;
         addra     <= addra + ADDR_BITS'(1);
         addr_step <= 1'b1;
      end else begin
         cnt       <= cnt + DIV_BITS'(1);
         addr_step <= 1'b0;
      end
   end

   // Toggle has priority over a coinciding note-timer terminal count.
   always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
         tmr         <= '0;
         note_idx    <= '0;
         note_strobe <= 1'b0;
         arp_active  <= 1'b0;
         dir         <= DIR_UP;
      end else begin
         note_strobe <= 1'b0;
         if (toggle) begin
            arp_active <= !arp_active;
            tmr        <= '0;
            dir        <= DIR_UP;
            note_idx   <= (!arp_active && mode == MODE_DOWN) ? LAST_NOTE : 3'd0;
         end else if (arp_active) begin
            if (tmr == TMR_LAST) begin
               tmr <= '0;
               case (mode)
                  MODE_UP: begin
                     note_idx    <= (note_idx == LAST_NOTE) ? 3'd0 : note_idx + 3'd1;
                     note_strobe <= 1'b1;
                  end
                  MODE_DOWN: begin
                     note_idx    <= (note_idx == 3'd0) ? LAST_NOTE : note_idx - 3'd1;
                     note_strobe <= 1'b1;
                  end
                  MODE_BOUNCE: begin
                     note_strobe <= 1'b1;
                     if (note_idx == LAST_NOTE) begin
                        note_idx <= note_idx - 3'd1;
                        dir      <= DIR_DOWN;
                     end else if (note_idx == 3'd0) begin
                        note_idx <= 3'd1;
                        dir      <= DIR_UP;
                     end else if (dir == DIR_UP) begin
                        note_idx <= note_idx + 3'd1;
                     end else begin
                        note_idx <= note_idx - 3'd1;
                     end
                  end
                  default: ;
               endcase
            end else begin
               tmr <= tmr + TW'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_arpeggio_sequencer.sv
// Scoreboard bench for arpeggio_sequencer: expected step periods and note indices are
// queued as stimulus is applied and compared when addr_step / note_strobe pulse.
module tb_arpeggio_sequencer;

   localparam int AW = 4;

   typedef struct {
      int idx;
      int gap;
   } strb_t;

   logic          CLK100MHZ = 1'b0;
   logic          CPU_RESETN = 1'b0;
   logic [7:0]    base_sel = '0;
   logic [1:0]    mode = '0;
   logic          toggle = 1'b0;
   logic [AW-1:0] addra;
   logic          addr_step;
   logic [2:0]    note_idx;
   logic          note_strobe;
   logic          arp_active;

   int    step_q[$];
   strb_t strb_q[$];
   int    n_vec = 0;
   int    n_err = 0;
   int    cyc = 0;
   int    last_step = 0;
   int    last_strb = 0;
   int    tog_cyc = 0;
   logic [AW-1:0] m_addr = '0;
   int    per[4] = '{756, 604, 504, 378};

   arpeggio_sequencer #(
      .NOTES(4), .NOTE_TICKS(10), .SW_BITS(8), .BASE_OFFSET(746),
      .DIV_BITS(12), .ADDR_BITS(AW)
   ) dut (
      .CLK100MHZ(CLK100MHZ), .CPU_RESETN(CPU_RESETN), .base_sel(base_sel),
      .mode(mode), .toggle(toggle), .addra(addra), .addr_step(addr_step),
      .note_idx(note_idx), .note_strobe(note_strobe), .arp_active(arp_active)
   );

   always #5 CLK100MHZ = ~CLK100MHZ;
   always @(posedge CLK100MHZ) cyc <= cyc + 1;

   task automatic chk_eq(input string tag, input longint obs, input longint exp);
      n_vec++;
      if (obs != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic chk_outs_zero(input string tag);
      chk_eq({tag, "_addra"}, addra, 0);
      chk_eq({tag, "_addr_step"}, addr_step, 0);
      chk_eq({tag, "_note_idx"}, note_idx, 0);
      chk_eq({tag, "_note_strobe"}, note_strobe, 0);
      chk_eq({tag, "_arp_active"}, arp_active, 0);
   endtask

   task automatic push_strb(input int idx, input int gap);
      strb_t s;
      s.idx = idx;
      s.gap = gap;
      strb_q.push_back(s);
   endtask

   task automatic drain(input int bound);
      int n;
      n = 0;
      while ((step_q.size() + strb_q.size()) != 0 && n < bound) begin
         @(negedge CLK100MHZ);
         #1;
         n++;
      end
      chk_eq("drain_timeout", step_q.size() + strb_q.size(), 0);
      step_q.delete();
      strb_q.delete();
   endtask

   // toggle is high across exactly one rising edge, recorded in tog_cyc
   task automatic pulse_toggle();
      @(negedge CLK100MHZ);
      #1 toggle = 1'b1;
      tog_cyc = cyc + 1;
      @(negedge CLK100MHZ);
      #1 toggle = 1'b0;
   endtask

   initial begin
      int    e;
      strb_t s;
      forever begin
         @(negedge CLK100MHZ);
         if (!CPU_RESETN) begin
            m_addr = '0;
         end else begin
            if (addr_step) begin
               m_addr = m_addr + AW'(1);
               chk_eq("addra", addra, m_addr);
               if (step_q.size() > 0) begin
                  e = step_q.pop_front();
                  if (e != 0) chk_eq("step_period", cyc - last_step, e);
               end
               last_step = cyc;
            end
            if (note_strobe) begin
               if (strb_q.size() > 0) begin
                  s = strb_q.pop_front();
                  chk_eq("note_idx", note_idx, s.idx);
                  if (s.gap != 0) chk_eq("strobe_gap", cyc - last_strb, s.gap);
               end else begin
                  chk_eq("strobe_unexpected", note_strobe, 0);
               end
               last_strb = cyc;
            end
         end
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      // reset state, then base-note stepping at 746
      repeat (3) @(negedge CLK100MHZ);
      #1;
      chk_outs_zero("reset");
      CPU_RESETN = 1'b1;
      last_step = cyc;
      repeat (3) step_q.push_back(746);
      drain(3000);

      // base_sel=10 changed right after a step; run through an address wrap
      base_sel = 8'd10;
      repeat (16) step_q.push_back(756);
      drain(13000);

      // up pattern
      mode = 2'b01;
      pulse_toggle();
      last_strb = tog_cyc;
      chk_eq("arp_on", arp_active, 1);
      chk_eq("up_start_idx", note_idx, 0);
      for (int i = 1; i <= 4; i++) push_strb(i % 4, 10);
      drain(100);

      // hold on each note to measure its step period
      for (int k = 0; k < 4; k++) begin
         if (k > 0) begin
            mode = 2'b01;
            push_strb(k, 0);
            drain(30);
         end
         mode = 2'b00;
         step_q.push_back(0);
         step_q.push_back(per[k]);
         drain(2000);
      end

      // divider shrinking below the running count fires on the next cycle
      mode = 2'b01;
      push_strb(0, 0);
      drain(30);
      mode = 2'b00;
      step_q.push_back(0);
      step_q.push_back(756);
      drain(2000);
      repeat (500) @(negedge CLK100MHZ);
      #1 mode = 2'b10;
      push_strb(3, 0);
      drain(30);
      step_q.push_back(last_strb + 3 - last_step);
      drain(20);
      mode = 2'b00;

      // up-down from 0, then down from toggle, then up-down entered at the top
      pulse_toggle();
      chk_eq("arp_off", arp_active, 0);
      chk_eq("off_idx", note_idx, 0);
      mode = 2'b11;
      pulse_toggle();
      last_strb = tog_cyc;
      chk_eq("bounce_start_idx", note_idx, 0);
      push_strb(1, 10); push_strb(2, 10); push_strb(3, 10); push_strb(2, 10);
      push_strb(1, 10); push_strb(0, 10); push_strb(1, 10);
      drain(100);
      pulse_toggle();
      mode = 2'b10;
      pulse_toggle();
      last_strb = tog_cyc;
      chk_eq("down_start_idx", note_idx, 3);
      push_strb(2, 10); push_strb(1, 10); push_strb(0, 10); push_strb(3, 10);
      drain(60);
      mode = 2'b11;
      push_strb(2, 10);
      drain(20);

      // toggle off during note 2: no strobe, base period returns
      repeat (3) @(negedge CLK100MHZ);
      pulse_toggle();
      chk_eq("mid_off_active", arp_active, 0);
      chk_eq("mid_off_idx", note_idx, 0);
      step_q.push_back(0);
      step_q.push_back(756);
      drain(2000);

      // toggle on the terminal-count edge wins over the note advance
      mode = 2'b01;
      pulse_toggle();
      chk_eq("tc_on_active", arp_active, 1);
      repeat (8) @(negedge CLK100MHZ);
      pulse_toggle();
      chk_eq("tc_toggle_active", arp_active, 0);
      chk_eq("tc_toggle_idx", note_idx, 0);
      repeat (20) @(negedge CLK100MHZ);

      // asynchronous reset between clock edges, then resume at 746
      pulse_toggle();
      last_strb = tog_cyc;
      chk_eq("pre_reset_active", arp_active, 1);
      repeat (5) @(negedge CLK100MHZ);
      #2 CPU_RESETN = 1'b0;
      #1 chk_outs_zero("async_reset");
      repeat (3) @(negedge CLK100MHZ);
      #1 base_sel = 8'd0;
      CPU_RESETN = 1'b1;
      last_step = cyc;
      step_q.push_back(746);
      step_q.push_back(746);
      drain(2000);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
